// File: rtl/pcie_pkg.sv
// Shared constants and types for the PCIe BAR write path.
// Packets are 128 bits wide and leave as four big-endian-ordered dwords.
package pcie_pkg;

  localparam int PCIE_ADDR_W = 11;
  localparam int PCIE_DW     = 32;
  localparam int PCIE_PKT_W  = 128;
  localparam int PCIE_BEATS  = 4;
  localparam int PCIE_GNT_W  = 2;
  localparam logic [7:0] PCIE_BE_ALL = 8'hFF;

  typedef enum logic {
    IDLE,
    WRITE
  } pcie_wr_state_t;

  // Word 0 is the most significant dword of the packet.
  function automatic logic [PCIE_DW-1:0] pkt_word(
    input logic [PCIE_PKT_W-1:0] pkt,
    input logic [1:0]            beat
  );
    logic [PCIE_DW-1:0] word;
    case (beat)
      2'd0:    word = pkt[127:96];
      2'd1:    word = pkt[95:64];
      2'd2:    word = pkt[63:32];
      default: word = pkt[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after
// (last + 1) mod N wins, searching upward and wrapping.
module rr_arbiter
  import pcie_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            req,
  input  logic [PCIE_GNT_W-1:0]   last,
  output logic [N-1:0]            gnt,
  output logic [PCIE_GNT_W-1:0]   idx,
  output logic                    any
);

  int best;
  int rank;

  // Rank is the distance from the slot just after the last winner.
  always_comb begin
    best = N;
    rank = 0;
    idx  = '0;
    for (int c = 0; c < N; c++) begin
      if (req[c]) begin
        rank = (c + N - 1 - int'(last)) % N;
        if (rank < best) begin
          best = rank;
          idx  = PCIE_GNT_W'(c);
        end
      end
    end
    any = (best < N);
    gnt = '0;
    for (int c = 0; c < N; c++) begin
      gnt[c] = any && (idx == PCIE_GNT_W'(c));
    end
  end

endmodule

// File: rtl/pcie_wr_arbiter.sv
// Round-robin arbiter that serialises 128-bit packets from NREQ sources
// into dword writes on the shared BAR port, one ring region per source.
module pcie_wr_arbiter
  import pcie_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int REGION_BITS = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ*PCIE_PKT_W-1:0]  req_data,
  output logic [NREQ-1:0]             req_ready,
  output logic [PCIE_ADDR_W-1:0]      ram_addr,
  output logic [PCIE_DW-1:0]          ram_data,
  output logic [7:0]                  ram_be,
  output logic                        ram_we,
  input  logic                        ram_busy,
  output logic [PCIE_GNT_W-1:0]       grant_id,
  output logic                        pkt_done,
  output logic [NREQ*REGION_BITS-1:0] wr_ptr
);

  pcie_wr_state_t          state;
  logic [1:0]              beat;
  logic [PCIE_PKT_W-1:0]   pkt_q;
  logic [PCIE_GNT_W-1:0]   last_grant;
  logic [REGION_BITS-1:0]  ptr_q [NREQ];

  logic [NREQ-1:0]         arb_gnt;
  logic [PCIE_GNT_W-1:0]   arb_idx;
  logic                    arb_any;
  logic [PCIE_PKT_W-1:0]   sel_data;
  logic [REGION_BITS-1:0]  cur_ptr;
  logic [PCIE_ADDR_W-1:0]  region_base;

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  assign ram_be    = PCIE_BE_ALL;
  assign req_ready = (rst_n && enable && state == IDLE) ? arb_gnt : '0;

  always_comb begin
    sel_data = '0;
    cur_ptr  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PCIE_GNT_W'(i)) sel_data = req_data[i*PCIE_PKT_W +: PCIE_PKT_W];
      if (grant_id == PCIE_GNT_W'(i)) cur_ptr = ptr_q[i];
    end
    region_base = PCIE_ADDR_W'(grant_id) << REGION_BITS;
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wr_ptr[i*REGION_BITS +: REGION_BITS] = ptr_q[i];
    end
  end

  // Strobes default low each cycle; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat       <= '0;
      pkt_q      <= '0;
      last_grant <= PCIE_GNT_W'(NREQ - 1);
      grant_id   <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      pkt_done   <= 1'b0;
      for (int i = 0; i < NREQ; i++) ptr_q[i] <= '0;
    end else begin
      ram_we   <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && arb_any) begin
            pkt_q    <= sel_data;
            grant_id <= arb_idx;
            beat     <= '0;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (!ram_busy) begin
            ram_we   <= 1'b1;
            ram_addr <= region_base + PCIE_ADDR_W'(cur_ptr);
            ram_data <= pkt_word(pkt_q, beat);
            for (int i = 0; i < NREQ; i++) begin
              if (grant_id == PCIE_GNT_W'(i)) ptr_q[i] <= ptr_q[i] + REGION_BITS'(1);
            end
            beat <= beat + 2'd1;
            if (beat == 2'(PCIE_BEATS - 1)) begin
              state      <= IDLE;
              pkt_done   <= 1'b1;
              last_grant <= grant_id;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_wr_arbiter.sv
// Scoreboard bench for pcie_wr_arbiter: accepted packets push four expected
// writes, observed writes pop and compare; the grant choice is modelled too.
module tb_pcie_wr_arbiter;

  localparam int NREQ = 2;
  localparam int RB   = 9;

  typedef struct packed {
    logic [10:0] addr;
    logic [31:0] data;
    logic        last;
    logic [1:0]  gid;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic                  enable;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*128-1:0]   req_data;
  logic [NREQ-1:0]       req_ready;
  logic [10:0]           ram_addr;
  logic [31:0]           ram_data;
  logic [7:0]            ram_be;
  logic                  ram_we;
  logic                  ram_busy;
  logic [1:0]            grant_id;
  logic                  pkt_done;
  logic [NREQ*RB-1:0]    wr_ptr;

  int   check_count = 0;
  int   pass_count  = 0;
  int   cyc = 0;
  int   last_acc_cyc = 0;
  int   last_done_cyc = 0;
  int   model_ptr [NREQ];
  int   model_last;
  int   mc;
  int   mw;
  exp_t sbq [$];
  exp_t pe;
  exp_t ge;
  logic [NREQ-1:0] exp_ready;
  logic [127:0]    dpkt;

  pcie_wr_arbiter #(
    .NREQ        (NREQ),
    .REGION_BITS (RB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_be    (ram_be),
    .ram_we    (ram_we),
    .ram_busy  (ram_busy),
    .grant_id  (grant_id),
    .pkt_done  (pkt_done),
    .wr_ptr    (wr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic modelReset();
    sbq.delete();
    for (int i = 0; i < NREQ; i++) model_ptr[i] = 0;
    model_last = NREQ - 1;
  endtask

  // Writes are checked first, so the cycle of the 4th write is already idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        if (sbq.size() == 0) begin
          checkOutput("spurious_we", 64'(ram_we), 64'(0));
        end else begin
          ge = sbq.pop_front();
          checkOutput("addr", 64'(ram_addr), 64'(ge.addr));
          checkOutput("data", 64'(ram_data), 64'(ge.data));
          checkOutput("gid", 64'(grant_id), 64'(ge.gid));
          checkOutput("done", 64'(pkt_done), 64'(ge.last));
        end
      end else begin
        checkOutput("idle_done", 64'(pkt_done), 64'(0));
      end
      if (pkt_done) last_done_cyc = cyc;

      exp_ready = '0;
      if (enable && sbq.size() == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          mc = (model_last + k) % NREQ;
          if (req_valid[mc] && exp_ready == '0) exp_ready[mc] = 1'b1;
        end
      end
      checkOutput("ready", 64'(req_ready), 64'(exp_ready));

      if (|exp_ready) begin
        mw = 0;
        for (int k = 0; k < NREQ; k++) if (exp_ready[k]) mw = k;
        dpkt = req_data[mw*128 +: 128];
        for (int b = 0; b < 4; b++) begin
          pe.addr = 11'((mw << RB) + ((model_ptr[mw] + b) % 512));
          pe.data = dpkt[127-32*b -: 32];
          pe.last = (b == 3);
          pe.gid  = 2'(mw);
          sbq.push_back(pe);
        end
        model_ptr[mw] = (model_ptr[mw] + 4) % 512;
        model_last    = mw;
        last_acc_cyc  = cyc + 1;
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input int r, input logic [127:0] d);
    bit accepted;
    accepted = 1'b0;
    req_data[r*128 +: 128] = d;
    req_valid[r] = 1'b1;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      if (req_ready[r]) accepted = 1'b1;
    end
    checkOutput("accept_timeout", 64'(accepted), 64'(1));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #1;
    checkOutput("drain", 64'(sbq.size()), 64'(0));
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ram_busy  = 1'b0;
    modelReset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_we", 64'(ram_we), 64'(0));
    checkOutput("rst_addr", 64'(ram_addr), 64'(0));
    checkOutput("rst_data", 64'(ram_data), 64'(0));
    checkOutput("rst_done", 64'(pkt_done), 64'(0));
    checkOutput("rst_gid", 64'(grant_id), 64'(0));
    checkOutput("rst_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_ptr", 64'(wr_ptr), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] single packet");
    applyStimulus(0, 128'h11110020333344445555666677778888);
    waitDrain();
    checkOutput("single_lat", 64'(last_done_cyc - last_acc_cyc), 64'(4));
    checkOutput("single_ptr0", 64'(wr_ptr[8:0]), 64'(4));
    checkOutput("be", 64'(ram_be), 64'(8'hFF));

    $display("[TB] contention");
    fork
      begin
        for (int p = 0; p < 4; p++) applyStimulus(0, rnd128());
      end
      begin
        for (int p = 0; p < 4; p++) applyStimulus(1, rnd128());
      end
    join
    waitDrain();
    checkOutput("cont_ptr0", 64'(wr_ptr[8:0]), 64'(20));
    checkOutput("cont_ptr1", 64'(wr_ptr[17:9]), 64'(16));

    $display("[TB] busy stall");
    applyStimulus(0, rnd128());
    @(posedge clk); #1;
    @(posedge clk); #1;
    ram_busy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    ram_busy = 1'b0;
    waitDrain();
    checkOutput("stall_lat", 64'(last_done_cyc - last_acc_cyc), 64'(7));
    checkOutput("stall_ptr0", 64'(wr_ptr[8:0]), 64'(24));

    $display("[TB] ring wrap");
    applyReset();
    for (int p = 0; p < 129; p++) applyStimulus(0, rnd128());
    waitDrain();
    checkOutput("wrap_ptr0", 64'(wr_ptr[8:0]), 64'(4));
    checkOutput("wrap_ptr1", 64'(wr_ptr[17:9]), 64'(0));

    $display("[TB] enable gating");
    applyStimulus(0, rnd128());
    enable    = 1'b0;
    req_valid = 2'b11;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checkOutput("gated_ready", 64'(req_ready), 64'(0));
    end
    checkOutput("gated_drain", 64'(sbq.size()), 64'(0));
    @(posedge clk); #1;
    req_valid = '0;
    enable    = 1'b1;

    $display("[TB] reset mid-packet");
    applyStimulus(1, rnd128());
    @(posedge clk); #1;
    rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_we", 64'(ram_we), 64'(0));
    checkOutput("mid_rst_ptr", 64'(wr_ptr), 64'(0));
    checkOutput("mid_rst_done", 64'(pkt_done), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_data[127:0]   = rnd128();
    req_data[255:128] = rnd128();
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("post_rst_winner", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    applyStimulus(1, rnd128());
    waitDrain();
    checkOutput("post_rst_ptr0", 64'(wr_ptr[8:0]), 64'(4));
    checkOutput("post_rst_ptr1", 64'(wr_ptr[17:9]), 64'(4));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
